// File: rtl/pwm_ramp_controller.sv
// Soft-start/soft-stop sequencer for the 8-bit PWM generator: slews PWM_ontime toward a
// handshaked target by STEP, only on period_tick. Define PWM_RAMP_LIMIT_EN to clamp targets to MAX_DUTY.
module pwm_ramp_controller #(
  parameter int WIDTH    = 8,
  parameter int PERIOD   = 256,
  parameter int STEP     = 4,
  parameter int DWELL    = 1,
  parameter int MAX_DUTY = 240
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             tgt_valid,
  input  logic [WIDTH-1:0] tgt_duty,
  output logic             tgt_ready,
  output logic [WIDTH-1:0] PWM_ontime,
  output logic             period_tick,
  output logic             busy,
  output logic             at_target
`ifdef PWM_RAMP_LIMIT_EN
  ,
  output logic             clamped
`endif
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
`ifdef PWM_RAMP_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif
  // Without the limit feature the ceiling is full scale, so no target is ever altered.
  localparam int CEIL = LIMIT_EN ? MAX_DUTY : (2**WIDTH) - 1;
  localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0] CEIL_X = (WIDTH+1)'(CEIL);

  typedef enum logic [1:0] {OFF, RAMP, HOLD, STOP} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic [WIDTH-1:0] ontime_q, ontime_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] goal, tgt_in, stepped;
  logic [WIDTH:0]   ont_x, goal_x, up_x, dn_lim_x;
  logic             update, xfer, over;

  assign period_tick = (cnt_q == CW'(PERIOD - 1));
  assign update      = period_tick && (dwell_q == DW'(DWELL - 1));
  assign cnt_d       = period_tick ? '0 : cnt_q + CW'(1);
  assign dwell_d     = update ? '0 : (period_tick ? dwell_q + DW'(1) : dwell_q);

  assign tgt_ready = reset && (state_q != STOP);
  assign xfer      = tgt_valid && tgt_ready;
  assign over      = ({1'b0, tgt_duty} > CEIL_X);
  assign tgt_in    = over ? CEIL_X[WIDTH-1:0] : tgt_duty;
  assign tgt_d     = xfer ? tgt_in : tgt_q;
  assign goal      = (state_q == RAMP || state_q == HOLD) ? tgt_q : '0;

  // Step math one bit wider than the duty so neither direction can wrap past the goal.
  assign ont_x    = {1'b0, ontime_q};
  assign goal_x   = {1'b0, goal};
  assign up_x     = ont_x + STEP_X;
  assign dn_lim_x = goal_x + STEP_X;

  always_comb begin
    stepped = ontime_q;
    if (ont_x < goal_x)
      stepped = (up_x > goal_x) ? goal : up_x[WIDTH-1:0];
    else if (ont_x > goal_x)
      stepped = (ont_x < dn_lim_x) ? goal : ontime_q - STEP_X[WIDTH-1:0];
  end

  always_comb begin
    state_d  = state_q;
    ontime_d = ontime_q;
    if (update && (state_q == RAMP || state_q == STOP))
      ontime_d = stepped;
    case (state_q)
      OFF: begin
        if (enable) state_d = (tgt_d == '0) ? HOLD : RAMP;
      end
      RAMP: begin
        // Compare against tgt_d: a target landing on the update edge must keep us ramping.
        if (!enable)                          state_d = STOP;
        else if (update && ontime_d == tgt_d) state_d = HOLD;
      end
      HOLD: begin
        if (!enable)                        state_d = STOP;
        else if (xfer && tgt_d != ontime_q) state_d = RAMP;
      end
      STOP: begin
        if (enable)               state_d = RAMP;
        else if (ontime_d == '0)  state_d = OFF;
      end
      default: state_d = OFF;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= OFF;
      cnt_q    <= '0;
      dwell_q  <= '0;
      ontime_q <= '0;
      tgt_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dwell_q  <= dwell_d;
      ontime_q <= ontime_d;
      tgt_q    <= tgt_d;
    end
  end

  assign PWM_ontime = ontime_q;
  assign busy       = (state_q == RAMP || state_q == STOP) && (ontime_q != goal);
  assign at_target  = (state_q == HOLD);

`ifdef PWM_RAMP_LIMIT_EN
  logic clamped_q;

  // Every transfer rewrites the flag, so a later unclamped target clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    clamped_q <= 1'b0;
    else if (xfer) clamped_q <= over;
  end

  assign clamped = clamped_q;
`endif

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Bench for pwm_ramp_controller: directed ramp scenarios plus random traffic, scored against
// an arithmetic duty model through a per-tick expectation queue.
module tb_pwm_ramp_controller;
  localparam int W    = 8;
  localparam int P    = 16;
  localparam int ST   = 4;
  localparam int MAXD = 240;

  logic         clk = 1'b0, reset = 1'b0, enable = 1'b0, tgt_valid = 1'b0;
  logic [W-1:0] tgt_duty = '0;
  logic         tgt_ready, period_tick, busy, at_target;
  logic [W-1:0] PWM_ontime;
`ifdef PWM_RAMP_LIMIT_EN
  logic         clamped;
`endif

  pwm_ramp_controller #(.WIDTH(W), .PERIOD(P), .STEP(ST), .DWELL(1), .MAX_DUTY(MAXD)) dut (
    .clk(clk), .reset(reset), .enable(enable), .tgt_valid(tgt_valid), .tgt_duty(tgt_duty),
    .tgt_ready(tgt_ready), .PWM_ontime(PWM_ontime), .period_tick(period_tick),
    .busy(busy), .at_target(at_target)
`ifdef PWM_RAMP_LIMIT_EN
    , .clamped(clamped)
`endif
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: mode 0=off, 1=running toward target, 2=stopping toward 0.
  int m_on = 0, m_tgt = 0, m_mode = 0, m_cnt = 0;
  bit m_clamp = 1'b0;
  typedef struct { int on; bit chk; bit at; } exp_t;
  exp_t q[$];

  function automatic int stepf(input int on, input int goal);
    if (on < goal) return (on + ST > goal) ? goal : on + ST;
    if (on > goal) return (on - ST < goal) ? goal : on - ST;
    return on;
  endfunction

  initial begin
    bit tick, xf;
    int pm, d;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_on = 0; m_tgt = 0; m_mode = 0; m_cnt = 0; m_clamp = 1'b0;
        q.delete();
      end else begin
        tick  = (m_cnt == P - 1);
        pm    = m_mode;
        xf    = tgt_valid && (m_mode != 2);
        m_cnt = (m_cnt + 1) % P;
        if (tick) begin
          if (m_mode == 1)      m_on = stepf(m_on, m_tgt);
          else if (m_mode == 2) m_on = stepf(m_on, 0);
        end
        if (xf) begin
          d = int'(tgt_duty);
`ifdef PWM_RAMP_LIMIT_EN
          m_clamp = (d > MAXD);
          if (d > MAXD) d = MAXD;
`endif
          m_tgt = d;
        end
        case (m_mode)
          0: if (enable) m_mode = 1;
          1: if (!enable) m_mode = 2;
          default: if (enable) m_mode = 1; else if (m_on == 0) m_mode = 0;
        endcase
        if (tick) q.push_back('{m_on, (pm == 1) && (m_mode == 1), m_on == m_tgt});
      end
    end
  end

  // Monitor: pops one expectation per DUT period_tick; between ticks the duty must not move.
  initial begin
    bit pt = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      chk("tgt_ready", int'(tgt_ready), int'(reset && m_mode != 2));
      chk("period_tick", int'(period_tick), int'(reset && m_cnt == P - 1));
      if (!reset) begin
        chk("rst_busy", int'(busy), 0);
        chk("rst_at_target", int'(at_target), 0);
      end
      if (pt && reset) begin
        if (q.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL tick_pop: DUT ticked with no expected update queued (t=%0t)", $time);
        end else begin
          e = q.pop_front();
          chk("tick_ontime", int'(PWM_ontime), e.on);
          if (e.chk) begin
            chk("at_target", int'(at_target), int'(e.at));
            chk("busy", int'(busy), int'(!e.at));
          end
        end
      end else begin
        chk("hold_ontime", int'(PWM_ontime), m_on);
      end
`ifdef PWM_RAMP_LIMIT_EN
      chk("clamped", int'(clamped), int'(m_clamp));
`endif
      pt = reset && period_tick;
    end
  end

  task automatic send(input int d);
    tgt_valid = 1'b1;
    tgt_duty  = W'(d);
    @(negedge clk);
    tgt_valid = 1'b0;
  endtask

  task automatic wait_tick_cycle(input string nm);
    int n = 0;
    while (!period_tick && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) begin
      nvec++; nerr++;
      $display("FAIL %s: no period_tick within 40 cycles", nm);
    end
  endtask

  task automatic nxt(input string nm, input int v);
    wait_tick_cycle(nm);
    @(negedge clk);
    chk(nm, int'(PWM_ontime), v);
  endtask

  task automatic wait_hold(input string nm);
    int n = 0;
    while (!at_target && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) begin
      nvec++; nerr++;
      $display("FAIL %s: at_target not reached within 2000 cycles", nm);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;

    // Soft-start to 10
    @(negedge clk);
    enable = 1'b1;
    send(10);
    nxt("start_4", 4); nxt("start_8", 8); nxt("start_10", 10);
    chk("start_at_target", int'(at_target), 1);
    chk("start_busy", int'(busy), 0);

    // Soft-stop from 10; target offered during STOP must be refused
    enable = 1'b0;
    @(negedge clk);
    chk("stop_ready", int'(tgt_ready), 0);
    send(77);
    nxt("stop_6", 6); nxt("stop_2", 2); nxt("stop_0", 0);
    chk("off_ready", int'(tgt_ready), 1);

    // Ramp to 20; retarget to 50 on the update edge that reaches 20
    enable = 1'b1;
    send(20);
    nxt("sim_4", 4); nxt("sim_8", 8); nxt("sim_12", 12); nxt("sim_16", 16);
    wait_tick_cycle("sim_edge");
    tgt_valid = 1'b1;
    tgt_duty  = W'(50);
    @(negedge clk);
    tgt_valid = 1'b0;
    chk("sim_20", int'(PWM_ontime), 20);
    for (int v = 24; v <= 48; v += 4) nxt("sim_up", v);
    nxt("sim_50", 50);
    chk("sim_at_target", int'(at_target), 1);

    // Up to 200, then retarget down to 190
    send(200);
    wait_hold("hold_200");
    chk("hold_200", int'(PWM_ontime), 200);
    send(190);
    nxt("down_196", 196); nxt("down_192", 192); nxt("down_190", 190);

    // Mid-run reset while ramping
    send(100);
    repeat (40) @(negedge clk);
    #1 reset = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ontime", int'(PWM_ontime), 0);
    chk("rst_ready", int'(tgt_ready), 0);
    chk("rst_tick", int'(period_tick), 0);
    #1 reset = 1'b1;
    repeat (40) @(negedge clk);

`ifdef PWM_RAMP_LIMIT_EN
    enable = 1'b1;
    send(250);
    chk("clamp_set", int'(clamped), 1);
    wait_hold("clamp_hold");
    chk("clamp_240", int'(PWM_ontime), MAXD);
    send(100);
    chk("clamp_clr", int'(clamped), 0);
`endif

    // Random traffic
    repeat (4000) begin
      @(negedge clk);
      if ($urandom_range(63) == 0) enable = ~enable;
      tgt_valid = ($urandom_range(7) == 0);
      tgt_duty  = W'($urandom_range(255));
    end
    tgt_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/pwm_ramp_controller.md
Name: pwm_ramp_controller

Overview:
- Sequencer that drives the PWM_ontime input of the team's 8-bit PWM generator.
- Accepts a target duty over a valid/ready handshake.
- Slews PWM_ontime toward the target by a fixed step, updating only at PWM period boundaries (soft-start / soft-stop), so the generator never sees a mid-period duty change.
- Sits between the control/register logic and PWM_generator.

Parameters:
- WIDTH, 8, duty width; matches the generator's PWM_ontime width.
- PERIOD, 256, clocks per PWM period; must equal the generator's period.
- STEP, 4, duty change per update (1..2^WIDTH-1).
- DWELL, 1, PWM periods between successive updates (>=1).
- MAX_DUTY, 240, clamp ceiling; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  level; 1 = run/ramp to target, 0 = ramp down to 0 and stop.
- tgt_valid  in  1  new target offered.
- tgt_duty  in  WIDTH  target duty value.
- tgt_ready  out  1  controller can accept a target this cycle.
- PWM_ontime  out  WIDTH  duty to the generator; changes only on period_tick.
- period_tick  out  1  one-clock pulse in the last clock of each period.
- busy  out  1  1 while PWM_ontime != current goal.
- at_target  out  1  1 in HOLD.

Behaviour:
- Reset (reset=0, async) state:
  - state=OFF; PWM_ontime=0; latched target=0.
  - Period counter=0; dwell counter=0.
  - tgt_ready=0; busy=0; at_target=0; period_tick=0.
- Period counter:
  - Counts 0..PERIOD-1 and wraps.
  - Runs in every state after reset release.
  - period_tick=1 when count==PERIOD-1.
- Handshake:
  - Transfer when tgt_valid && tgt_ready on a rising edge.
  - tgt_ready=1 in OFF, RAMP and HOLD; tgt_ready=0 in STOP.
  - The accepted value is latched the same edge. It replaces any in-flight target; direction is re-evaluated at the next update.
- Update event:
  - Fires on a period_tick when the dwell counter reaches DWELL-1; the dwell counter resets at each update.
  - With DWELL=1, every period_tick is an update.
- Step arithmetic:
  - Up: next = min(ontime+STEP, goal). Down: next = max(ontime-STEP, goal).
  - Computed at WIDTH+1 bits; never overshoots, never wraps.
  - Goal = latched target in RAMP/HOLD; goal = 0 in STOP.
- States:
  - OFF: ontime=0. enable=1 -> RAMP next cycle (HOLD if target==0).
  - RAMP: step at each update.
    - ontime==goal after an update -> HOLD.
    - enable=0 -> STOP.
  - HOLD: ontime constant; at_target=1.
    - New target != ontime -> RAMP.
    - enable=0 -> STOP.
  - STOP: step toward 0 at each update.
    - ontime==0 -> OFF.
    - enable=1 -> RAMP toward the latched target, without waiting for 0.
- Simultaneous events:
  - enable falling and a target transfer in the same cycle: the target is latched, the state goes to STOP.
  - Target accepted on the same edge as an update: the update uses the previous goal; the new goal applies from the next update.
- Latency: PWM_ontime changes exactly on the clock edge at which period_tick is 1; never at any other time.
- Mid-operation reset: all registers return to reset values immediately; PWM_ontime=0 without ramping.

Optional Feature:
- Macro: PWM_RAMP_LIMIT_EN.
- Defined:
  - An accepted tgt_duty > MAX_DUTY is latched as MAX_DUTY.
  - An extra output port, clamped (1 bit), goes high on that transfer. It is sticky and is cleared by the next unclamped transfer or by reset.
- Undefined: targets are latched unmodified (full 0..2^WIDTH-1), and the clamped port does not exist.

Test Plan:
- Bench configuration for all scenarios: PERIOD=16, STEP=4, DWELL=1.
- Reset: hold reset=0 for 3 cycles mid-run -> PWM_ontime=0, tgt_ready=0, state OFF; release reset -> period_tick every 16 clocks.
- Soft-start: enable=1, target 10 -> PWM_ontime 4, 8, 10 on successive period_ticks; then at_target=1, busy=0.
- Retarget down: in HOLD at 200, send target 190 -> 196, 192, 190; assert no change between ticks.
- Soft-stop: at 10, drop enable -> tgt_ready=0; 6, 2, 0 on ticks; then OFF. A tgt_valid during STOP is not accepted.
- Simultaneous: tgt_valid with target 50 on the same edge as an update while ramping to 20 from 16 -> that tick gives 20; next ticks give 24 ... 48, 50.
- With PWM_RAMP_LIMIT_EN: target 250 -> latched 240, clamped=1; ramp ends at 240. Then target 100 -> clamped=0.
